shift_arbiter: RTL and testbench

Round-robin arbiter sharing one 8-bit `barrel_shift` instance between two requesters. Each requester presents a shift command over a valid/ready handshake. The winning command passes through the shifter and its result is captured in a one-deep registered output slot tagged with the requester id. Per-requester completion counters are kept for debug and performance visibility.

---
 rtl/shift_arbiter.sv | 178 +++++++++++++++++
 tb/tb_shift_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shift / shift_arbiter
//  Brief    : Two-requester round-robin arbiter in front of a shared 8-bit
//             barrel shifter, with a one-deep registered result slot and
//             per-requester completion counters.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  barrel_shift: 8-bit, 3-stage logarithmic shifter.
//  {op,dir} = 00 logical right, x1 left zero fill, 10 arithmetic right.
// ----------------------------------------------------------------------------
module barrel_shift (
    input  logic [7:0] i_din,
    input  logic [2:0] i_shamt,
    input  logic       i_dir,
    input  logic       i_op,
    output logic [7:0] o_dout
);

    logic       w_fill;
    logic [7:0] w_s1;
    logic [7:0] w_s2;
    logic [7:0] w_s4;

    // Sign fill only applies to arithmetic right shifts; left shifts fill zero.
    assign w_fill = i_op & ~i_dir & i_din[7];

    // Shift by 1, 2 and 4 in successive stages selected by the amount bits.
    always_comb begin
        w_s1 = i_din;
        if (i_shamt[0]) begin
            w_s1 = i_dir ? {i_din[6:0], 1'b0} : {w_fill, i_din[7:1]};
        end
        w_s2 = w_s1;
        if (i_shamt[1]) begin
            w_s2 = i_dir ? {w_s1[5:0], 2'b00} : {{2{w_fill}}, w_s1[7:2]};
        end
        w_s4 = w_s2;
        if (i_shamt[2]) begin
            w_s4 = i_dir ? {w_s2[3:0], 4'b0000} : {{4{w_fill}}, w_s2[7:4]};
        end
    end

    assign o_dout = w_s4;

endmodule

// ----------------------------------------------------------------------------
//  shift_arbiter: top level.
// ----------------------------------------------------------------------------
module shift_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_din,
    input  logic [2:0] req0_shamt,
    input  logic       req0_dir,
    input  logic       req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_din,
    input  logic [2:0] req1_shamt,
    input  logic       req1_dir,
    input  logic       req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_src,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_rsp_src;
    logic       r_last_grant;
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    logic       w_can_accept;
    logic       w_any_valid;
    logic       w_grant;
    logic       w_accept;
    logic       w_consume;
    logic [7:0] w_sh_din;
    logic [2:0] w_sh_shamt;
    logic       w_sh_dir;
    logic       w_sh_op;
    logic [7:0] w_sh_dout;

    // The slot can take a new command when empty or draining this cycle.
    assign w_can_accept = ~r_rsp_valid | rsp_ready;
    assign w_any_valid  = req0_valid | req1_valid;

    // Round-robin grant: on contention the requester that did not win last.
    // Depends only on valids and last_grant, never on payload or readies.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = w_can_accept & w_any_valid & ~w_grant;
    assign req1_ready = w_can_accept & w_any_valid &  w_grant;

    // A granted requester is by construction valid, so acceptance needs no
    // further qualification.
    assign w_accept  = w_can_accept & w_any_valid;
    assign w_consume = r_rsp_valid & rsp_ready;

    // Steer the granted payload into the shared shifter.
    always_comb begin
        w_sh_din   = req0_din;
        w_sh_shamt = req0_shamt;
        w_sh_dir   = req0_dir;
        w_sh_op    = req0_op;
        if (w_grant) begin
            w_sh_din   = req1_din;
            w_sh_shamt = req1_shamt;
            w_sh_dir   = req1_dir;
            w_sh_op    = req1_op;
        end
    end

    barrel_shift u_barrel_shift (
        .i_din   (w_sh_din),
        .i_shamt (w_sh_shamt),
        .i_dir   (w_sh_dir),
        .i_op    (w_sh_op),
        .o_dout  (w_sh_dout)
    );

    // Result slot and arbitration history; refill takes priority over drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_rsp_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= w_sh_dout;
            r_rsp_src    <= w_grant;
            r_last_grant <= w_grant;
        end else if (w_consume) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    // Completion counters bump on consume, attributed to the slot's source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= 8'h00;
            r_cnt1 <= 8'h00;
        end else if (w_consume) begin
            if (r_rsp_src) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end else begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_src   = r_rsp_src;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_arbiter
//  Brief    : Directed, table-driven self-checking bench for shift_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_dir, req0_op;
    logic [7:0] req0_din;
    logic [2:0] req0_shamt;
    logic       req1_valid, req1_ready, req1_dir, req1_op;
    logic [7:0] req1_din;
    logic [2:0] req1_shamt;
    logic       rsp_valid, rsp_ready, rsp_src;
    logic [7:0] rsp_data, cnt0, cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_din   (req0_din),
        .req0_shamt (req0_shamt),
        .req0_dir   (req0_dir),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_din   (req1_din),
        .req1_shamt (req1_shamt),
        .req1_dir   (req1_dir),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command encoding: {valid, din[7:0], shamt[2:0], dir, op}
    localparam logic [13:0] C_NONE = 14'd0;
    localparam logic [13:0] C_A = {1'b1, 8'hB4, 3'd2, 1'b0, 1'b1}; // -> ED
    localparam logic [13:0] C_B = {1'b1, 8'h81, 3'd1, 1'b1, 1'b0}; // -> 02
    localparam logic [13:0] C_C = {1'b1, 8'h81, 3'd3, 1'b0, 1'b0}; // -> 10
    localparam logic [13:0] C_D = {1'b1, 8'h96, 3'd7, 1'b0, 1'b1}; // -> FF
    localparam logic [13:0] C_E = {1'b1, 8'h0F, 3'd4, 1'b1, 1'b1}; // -> F0
    localparam logic [13:0] C_F = {1'b1, 8'h5A, 3'd0, 1'b0, 1'b0}; // -> 5A

    typedef struct {
        logic        rst;
        logic [13:0] c0;
        logic [13:0] c1;
        logic        rr;
        logic        erdy0;
        logic        erdy1;
        logic        erv;
        logic [7:0]  erd;
        logic        ers;
        logic [7:0]  ec0;
        logic [7:0]  ec1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [13:0] a, logic [13:0] b, logic rr,
                                logic e0, logic e1, logic ev, logic [7:0] ed,
                                logic es, logic [7:0] k0, logic [7:0] k1);
        vec_t v;
        v.rst = r; v.c0 = a; v.c1 = b; v.rr = rr;
        v.erdy0 = e0; v.erdy1 = e1; v.erv = ev; v.erd = ed; v.ers = es;
        v.ec0 = k0; v.ec1 = k1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [13:0] a, input logic [13:0] b, input logic rr);
        rst        = r;
        req0_valid = a[13]; req0_din = a[12:5]; req0_shamt = a[4:2];
        req0_dir   = a[1];  req0_op  = a[0];
        req1_valid = b[13]; req1_din = b[12:5]; req1_shamt = b[4:2];
        req1_dir   = b[1];  req1_op  = b[0];
        rsp_ready  = rr;
    endtask

    initial begin
        //           rst cmd0  cmd1  rr  rdy0 rdy1 rv  data   src c0    c1
        tbl.push_back(mk(1, C_NONE, C_NONE, 0, 0, 0, 0, 8'h00, 0, 8'd0, 8'd0));
        tbl.push_back(mk(0, C_A,    C_NONE, 1, 1, 0, 1, 8'hED, 0, 8'd0, 8'd0));
        tbl.push_back(mk(0, C_NONE, C_NONE, 1, 0, 0, 0, 8'hED, 0, 8'd1, 8'd0));
        tbl.push_back(mk(1, C_NONE, C_NONE, 1, 0, 0, 0, 8'h00, 0, 8'd0, 8'd0));
        // contention, alternating grants 0,1,0,1
        tbl.push_back(mk(0, C_B,    C_C,    1, 1, 0, 1, 8'h02, 0, 8'd0, 8'd0));
        tbl.push_back(mk(0, C_B,    C_C,    1, 0, 1, 1, 8'h10, 1, 8'd1, 8'd0));
        tbl.push_back(mk(0, C_B,    C_C,    1, 1, 0, 1, 8'h02, 0, 8'd1, 8'd1));
        tbl.push_back(mk(0, C_B,    C_C,    1, 0, 1, 1, 8'h10, 1, 8'd2, 8'd1));
        tbl.push_back(mk(0, C_NONE, C_NONE, 1, 0, 0, 0, 8'h10, 1, 8'd2, 8'd2));
        // fill, then stall three cycles with both valid (last_grant = 0)
        tbl.push_back(mk(0, C_B,    C_C,    0, 1, 0, 1, 8'h02, 0, 8'd2, 8'd2));
        tbl.push_back(mk(0, C_B,    C_C,    0, 0, 0, 1, 8'h02, 0, 8'd2, 8'd2));
        tbl.push_back(mk(0, C_B,    C_C,    0, 0, 0, 1, 8'h02, 0, 8'd2, 8'd2));
        tbl.push_back(mk(0, C_B,    C_C,    0, 0, 0, 1, 8'h02, 0, 8'd2, 8'd2));
        // unblock: drain + refill, req1 wins
        tbl.push_back(mk(0, C_B,    C_C,    1, 0, 1, 1, 8'h10, 1, 8'd3, 8'd2));
        tbl.push_back(mk(0, C_NONE, C_D,    1, 0, 1, 1, 8'hFF, 1, 8'd3, 8'd3));
        tbl.push_back(mk(0, C_NONE, C_E,    1, 0, 1, 1, 8'hF0, 1, 8'd3, 8'd4));
        tbl.push_back(mk(0, C_F,    C_NONE, 1, 1, 0, 1, 8'h5A, 0, 8'd3, 8'd5));
        tbl.push_back(mk(0, C_NONE, C_NONE, 0, 0, 0, 1, 8'h5A, 0, 8'd3, 8'd5));
        // reset with occupied slot and pending stalled commands
        tbl.push_back(mk(1, C_B,    C_C,    0, 0, 0, 0, 8'h00, 0, 8'd0, 8'd0));
        tbl.push_back(mk(0, C_B,    C_C,    1, 1, 0, 1, 8'h02, 0, 8'd0, 8'd0));
        tbl.push_back(mk(0, C_NONE, C_NONE, 1, 0, 0, 0, 8'h02, 0, 8'd1, 8'd0));

        drive(1'b1, C_NONE, C_NONE, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].c0, tbl[i].c1, tbl[i].rr);
            #1;
            check($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].erdy0));
            check($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].erdy1));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].erv));
            check($sformatf("v%0d rsp_data", i),  32'(rsp_data),  32'(tbl[i].erd));
            check($sformatf("v%0d rsp_src", i),   32'(rsp_src),   32'(tbl[i].ers));
            check($sformatf("v%0d cnt0", i),      32'(cnt0),      32'(tbl[i].ec0));
            check($sformatf("v%0d cnt1", i),      32'(cnt1),      32'(tbl[i].ec1));
        end

        // Counter wrap: 256 consumed results from requester 1 (cnt0 stays 1).
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            drive(1'b0, C_NONE, C_C, 1'b1);
            #1;
            check("wrap req1_ready", 32'(req1_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        check("wrap cnt1 at 255", 32'(cnt1), 32'd255);
        check("wrap rsp_data", 32'(rsp_data), 32'h10);
        @(negedge clk);
        drive(1'b0, C_NONE, C_NONE, 1'b1);
        @(posedge clk);
        #1;
        check("wrap cnt1 to 0", 32'(cnt1), 32'd0);
        check("wrap cnt0 held", 32'(cnt0), 32'd1);
        check("wrap rsp_valid drained", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
